// File: rtl/config_loader.sv
// Serial configuration-chain loader: clears the CGRA config chain, then streams
// exactly CHAIN_LEN bits (LSB of each word first) into its head while checking the tail.
module config_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CLR_CYC   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              config_reset,
  output logic              config_shift_en,
  output logic              config_out,
  input  logic              chain_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int WORDS  = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_W = CHAIN_LEN - (WORDS - 1) * WORD_W;
  localparam int WC_W   = $clog2(WORDS + 1);
  localparam int BC_W   = $clog2(CHAIN_LEN + 1);
  localparam int BL_W   = $clog2(WORD_W + 1);
  localparam int CC_W   = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

  localparam logic [WC_W-1:0] WORDS_C    = WC_W'(WORDS);
  localparam logic [WC_W-1:0] LAST_IDX_C = WC_W'(WORDS - 1);
  localparam logic [BC_W-1:0] LAST_BIT_C = BC_W'(CHAIN_LEN - 1);
  localparam logic [BL_W-1:0] WORD_W_C   = BL_W'(WORD_W);
  localparam logic [BL_W-1:0] LAST_W_C   = BL_W'(LAST_W);
  localparam logic [BL_W-1:0] ONE_BL_C   = BL_W'(1);
  localparam logic [CC_W-1:0] CLR_LAST_C = CC_W'(CLR_CYC - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_e;

  state_e            state_q, state_d;
  logic [CC_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BL_W-1:0]   buf_left_q, buf_left_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic              ready_q, ready_d;
  logic              cfg_reset_q, cfg_reset_d;
  logic              shift_en_q, shift_en_d;
  logic              out_q, out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              accept;
  logic [BL_W-1:0]   wbits;

  assign accept = ready_q && word_valid;
  // Only the low bits of the final word belong to the chain.
  assign wbits  = (word_cnt_q == LAST_IDX_C) ? LAST_W_C : WORD_W_C;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    word_cnt_d = word_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    buf_left_d = buf_left_q;
    sreg_d     = sreg_q;
    out_d      = out_q;
    shift_en_d = 1'b0;
    error_d    = error_q;

    // The chain was cleared, so a 1 at the tail means the chain is shorter than expected or broken.
    if (shift_en_q && chain_tail) error_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = CLEAR;
          clr_cnt_d  = '0;
          word_cnt_d = '0;
          bit_cnt_d  = '0;
          buf_left_d = '0;
          error_d    = 1'b0;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == CLR_LAST_C) state_d = SHIFT;
        else                         clr_cnt_d = clr_cnt_q + 1'b1;
      end
      SHIFT: begin
        if (buf_left_q != '0) begin
          out_d      = sreg_q[0];
          shift_en_d = 1'b1;
          sreg_d     = sreg_q >> 1;
          buf_left_d = buf_left_q - 1'b1;
          if (accept) begin
            sreg_d     = word_data;
            buf_left_d = wbits;
          end
        end else if (accept) begin
          // Empty buffer: shift straight from the incoming word to avoid a bubble.
          out_d      = word_data[0];
          shift_en_d = 1'b1;
          sreg_d     = word_data >> 1;
          buf_left_d = wbits - 1'b1;
        end
        if (accept) word_cnt_d = word_cnt_q + 1'b1;
        if (shift_en_d) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT_C) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d     = (state_d == SHIFT) && (word_cnt_d < WORDS_C) && (buf_left_d <= ONE_BL_C);
    cfg_reset_d = (state_d == CLEAR);
    busy_d      = (state_d == CLEAR) || (state_d == SHIFT);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      word_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      buf_left_q  <= '0;
      sreg_q      <= '0;
      ready_q     <= 1'b0;
      cfg_reset_q <= 1'b0;
      shift_en_q  <= 1'b0;
      out_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      word_cnt_q  <= word_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      buf_left_q  <= buf_left_d;
      sreg_q      <= sreg_d;
      ready_q     <= ready_d;
      cfg_reset_q <= cfg_reset_d;
      shift_en_q  <= shift_en_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign word_ready      = ready_q;
  assign config_reset    = cfg_reset_q;
  assign config_shift_en = shift_en_q;
  assign config_out      = out_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;

endmodule
